// File: rtl/regf_arb_pkg.sv
// Shared types and constants for the two-port register-file bus arbiter.
// Command/response structs are sized to the regf bus widths.
package regf_arb_pkg;

  localparam int   REQ_CNT     = 2;
  localparam int   SRC_W       = 1;
  localparam int   REGF_ADDR_W = 13;
  localparam int   REGF_DATA_W = 32;
  localparam logic LAST_RST    = 1'b1;

  typedef struct packed {
    logic [REGF_ADDR_W-1:0] addr;
    logic                   wena;
    logic [REGF_DATA_W-1:0] wdata;
    logic [SRC_W-1:0]       src;
  } regf_cmd_t;

  typedef struct packed {
    logic [REGF_DATA_W-1:0] rdata;
    logic                   err;
    logic [SRC_W-1:0]       src;
  } regf_rsp_t;

endpackage

// File: rtl/regf_rr_arb2.sv
// Combinational 2-way round-robin arbiter with lock qualification.
// A held lock admits only its owner; otherwise a tie goes to the non-last requester.
module regf_rr_arb2
  import regf_arb_pkg::*;
(
  input  logic [REQ_CNT-1:0] req,
  input  logic               last,
  input  logic               lock_vld,
  input  logic               lock_own,
  output logic [REQ_CNT-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (lock_vld) begin
      gnt[lock_own] = req[lock_own];
    end else if (&req) begin
      gnt[~last] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/regf_bus_arb.sv
// Shares one regf bus between two requesters: round-robin with lock,
// registered command and response stages for a fixed 2-cycle latency.
module regf_bus_arb
  import regf_arb_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              main_clk_i,
  input  logic              main_rst_i,
  input  logic              req0_ena_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic              req0_wena_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  input  logic              req0_lock_i,
  output logic              req0_gnt_o,
  output logic              req0_rvld_o,
  output logic [DATA_W-1:0] req0_rdata_o,
  output logic              req0_err_o,
  input  logic              req1_ena_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic              req1_wena_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  input  logic              req1_lock_i,
  output logic              req1_gnt_o,
  output logic              req1_rvld_o,
  output logic [DATA_W-1:0] req1_rdata_o,
  output logic              req1_err_o,
  output logic              mem_ena_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wena_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_err_i
);

  if ((ADDR_W != REGF_ADDR_W) || (DATA_W != REGF_DATA_W)) begin : g_bad_width
    $error("regf_bus_arb: ADDR_W/DATA_W must match regf_arb_pkg widths");
  end

  logic [REQ_CNT-1:0] req;
  logic [REQ_CNT-1:0] gnt_arb;
  logic [REQ_CNT-1:0] gnt;
  logic               gnt_idx;
  logic               gnt_lock;
  regf_cmd_t          cmd_next;

  logic               last_r;
  logic               lock_vld_r;
  logic               lock_own_r;
  logic               cmd_vld_r;
  regf_cmd_t          cmd_r;
  logic               rsp_vld_r;
  regf_rsp_t          rsp_r;

  assign req = {req1_ena_i, req0_ena_i};

  regf_rr_arb2 u_arb (
    .req      (req),
    .last     (last_r),
    .lock_vld (lock_vld_r),
    .lock_own (lock_own_r),
    .gnt      (gnt_arb)
  );

  assign gnt        = main_rst_i ? '0 : gnt_arb;
  assign gnt_idx    = gnt[1];
  assign req0_gnt_o = gnt[0];
  assign req1_gnt_o = gnt[1];

  always_comb begin
    cmd_next       = '0;
    cmd_next.addr  = gnt_idx ? req1_addr_i  : req0_addr_i;
    cmd_next.wena  = gnt_idx ? req1_wena_i  : req0_wena_i;
    cmd_next.wdata = gnt_idx ? req1_wdata_i : req0_wdata_i;
    cmd_next.src   = gnt_idx;
    gnt_lock       = gnt_idx ? req1_lock_i  : req0_lock_i;
  end

  // Grant -> command stage; an owner's unlocked grant drops the lock in the same cycle
  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      last_r     <= LAST_RST;
      lock_vld_r <= 1'b0;
      lock_own_r <= 1'b0;
      cmd_vld_r  <= 1'b0;
      cmd_r      <= '0;
      rsp_vld_r  <= 1'b0;
      rsp_r      <= '0;
    end else begin
      if (|gnt) begin
        last_r     <= gnt_idx;
        lock_vld_r <= gnt_lock;
        lock_own_r <= gnt_idx;
        cmd_r      <= cmd_next;
      end
      cmd_vld_r <= |gnt;
      // Command -> response stage
      if (cmd_vld_r) begin
        rsp_r.rdata <= cmd_r.wena ? '0 : mem_rdata_i;
        rsp_r.err   <= mem_err_i;
        rsp_r.src   <= cmd_r.src;
      end
      rsp_vld_r <= cmd_vld_r;
    end
  end

  assign mem_ena_o   = cmd_vld_r;
  assign mem_addr_o  = cmd_r.addr;
  assign mem_wena_o  = cmd_r.wena;
  assign mem_wdata_o = cmd_r.wdata;

  assign req0_rvld_o  = rsp_vld_r && (rsp_r.src == 1'b0);
  assign req1_rvld_o  = rsp_vld_r && (rsp_r.src == 1'b1);
  assign req0_rdata_o = req0_rvld_o ? rsp_r.rdata : '0;
  assign req1_rdata_o = req1_rvld_o ? rsp_r.rdata : '0;
  assign req0_err_o   = req0_rvld_o && rsp_r.err;
  assign req1_err_o   = req1_rvld_o && rsp_r.err;

endmodule

// File: tb/tb_regf_bus_arb.sv
// Directed bench for regf_bus_arb with a tiny combinational regf model.
module tb_regf_bus_arb;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              r0_ena, r0_wena, r0_lock, r0_gnt, r0_rvld, r0_err;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic              r1_ena, r1_wena, r1_lock, r1_gnt, r1_rvld, r1_err;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic              mem_ena, mem_wena, mem_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // regf model: address 0 reads 0x12, others 0xA500_0000|addr; address 4 decodes as error
  assign mem_rdata = (mem_addr == '0) ? 32'h12 : (32'hA500_0000 | {19'b0, mem_addr});
  assign mem_err   = mem_ena && (mem_addr == 13'h4);

  regf_bus_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .main_clk_i  (clk),
    .main_rst_i  (rst),
    .req0_ena_i  (r0_ena),   .req0_addr_i (r0_addr),  .req0_wena_i (r0_wena),
    .req0_wdata_i(r0_wdata), .req0_lock_i (r0_lock),  .req0_gnt_o  (r0_gnt),
    .req0_rvld_o (r0_rvld),  .req0_rdata_o(r0_rdata), .req0_err_o  (r0_err),
    .req1_ena_i  (r1_ena),   .req1_addr_i (r1_addr),  .req1_wena_i (r1_wena),
    .req1_wdata_i(r1_wdata), .req1_lock_i (r1_lock),  .req1_gnt_o  (r1_gnt),
    .req1_rvld_o (r1_rvld),  .req1_rdata_o(r1_rdata), .req1_err_o  (r1_err),
    .mem_ena_o   (mem_ena),  .mem_addr_o  (mem_addr), .mem_wena_o  (mem_wena),
    .mem_wdata_o (mem_wdata),.mem_rdata_i (mem_rdata),.mem_err_i   (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    r0_ena = 0; r0_addr = '0; r0_wena = 0; r0_wdata = '0; r0_lock = 0;
    r1_ena = 0; r1_addr = '0; r1_wena = 0; r1_wdata = '0; r1_lock = 0;
    tick; tick;

    // Reset state: gnt forced low, outputs zero
    r0_ena = 1; settle;
    chk("rst_gnt0", 32'(r0_gnt), 32'h0);
    chk("rst_mem_ena", 32'(mem_ena), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_rvld0", 32'(r0_rvld), 32'h0);
    r0_ena = 0;
    tick;
    rst = 1'b0;

    // Single read of 0x0000
    r0_ena = 1; r0_addr = 13'h0; r0_wena = 0; settle;
    chk("rd_gnt0", 32'(r0_gnt), 32'h1);
    chk("rd_gnt1", 32'(r1_gnt), 32'h0);
    tick; r0_ena = 0;
    chk("rd_mem_ena", 32'(mem_ena), 32'h1);
    chk("rd_mem_addr", 32'(mem_addr), 32'h0);
    chk("rd_mem_wena", 32'(mem_wena), 32'h0);
    tick;
    chk("rd_rvld0", 32'(r0_rvld), 32'h1);
    chk("rd_rdata0", r0_rdata, 32'h12);
    chk("rd_err0", 32'(r0_err), 32'h0);
    chk("rd_rvld1", 32'(r1_rvld), 32'h0);
    tick;
    chk("rd_rvld0_pulse", 32'(r0_rvld), 32'h0);

    // Tie after reset: grants alternate 0,1,0,1
    rst = 1'b1; tick; rst = 1'b0;
    r0_ena = 1; r0_addr = 13'h10; r1_ena = 1; r1_addr = 13'h21;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin r0_ena = 0; r1_ena = 0; end
      settle;
      if (i < 4) begin
        chk($sformatf("tie_gnt0_%0d", i), 32'(r0_gnt), 32'((i % 2) == 0));
        chk($sformatf("tie_gnt1_%0d", i), 32'(r1_gnt), 32'((i % 2) == 1));
      end
      if (i >= 1 && i <= 4)
        chk($sformatf("tie_addr_%0d", i), 32'(mem_addr), ((i % 2) == 1) ? 32'h10 : 32'h21);
      if (i >= 2) begin
        chk($sformatf("tie_rvld0_%0d", i), 32'(r0_rvld), 32'((i % 2) == 0));
        chk($sformatf("tie_rvld1_%0d", i), 32'(r1_rvld), 32'((i % 2) == 1));
        chk($sformatf("tie_rdata_%0d", i), ((i % 2) == 0) ? r0_rdata : r1_rdata,
            ((i % 2) == 0) ? 32'hA500_0010 : 32'hA500_0021);
      end
      tick;
    end

    // Lock: req1 locked read, req0 locked out until after req1's unlocking write
    r1_ena = 1; r1_addr = 13'h0; r1_wena = 0; r1_lock = 1; settle;
    chk("lk_gnt1_a", 32'(r1_gnt), 32'h1);
    tick;
    r1_ena = 0; r0_ena = 1; r0_addr = 13'h8; r0_wena = 0; settle;
    chk("lk_gnt0_idle", 32'(r0_gnt), 32'h0);
    chk("lk_gnt1_idle", 32'(r1_gnt), 32'h0);
    tick;
    r1_ena = 1; r1_addr = 13'h2; r1_wena = 1; r1_wdata = 32'h5A; r1_lock = 0; settle;
    chk("lk_gnt1_b", 32'(r1_gnt), 32'h1);
    chk("lk_gnt0_b", 32'(r0_gnt), 32'h0);
    chk("lk_rvld1_rd", 32'(r1_rvld), 32'h1);
    chk("lk_rdata1_rd", r1_rdata, 32'h12);
    tick;
    r1_ena = 0; settle;
    chk("lk_gnt0_after", 32'(r0_gnt), 32'h1);
    chk("lk_mem_wena", 32'(mem_wena), 32'h1);
    chk("lk_mem_addr", 32'(mem_addr), 32'h2);
    chk("lk_mem_wdata", mem_wdata, 32'h5A);
    tick;
    r0_ena = 0;
    chk("lk_rvld1_wr", 32'(r1_rvld), 32'h1);
    chk("lk_rdata1_wr", r1_rdata, 32'h0);
    tick;
    chk("lk_rvld0", 32'(r0_rvld), 32'h1);
    chk("lk_rdata0", r0_rdata, 32'hA500_0008);
    tick;

    // Decode error on a write
    r0_ena = 1; r0_addr = 13'h4; r0_wena = 1; r0_wdata = 32'hFFFF; settle;
    chk("de_gnt0", 32'(r0_gnt), 32'h1);
    tick; r0_ena = 0;
    tick;
    chk("de_rvld0", 32'(r0_rvld), 32'h1);
    chk("de_err0", 32'(r0_err), 32'h1);
    chk("de_rdata0", r0_rdata, 32'h0);
    tick;

    // Reset mid-flight with a lock held by req1
    r1_ena = 1; r1_addr = 13'h3; r1_wena = 0; r1_lock = 1; settle;
    chk("mf_gnt1", 32'(r1_gnt), 32'h1);
    tick;
    r1_ena = 0; r1_lock = 0; rst = 1'b1; settle;
    chk("mf_mem_ena_t1", 32'(mem_ena), 32'h1);
    tick;
    rst = 1'b0;
    chk("mf_rvld0", 32'(r0_rvld), 32'h0);
    chk("mf_rvld1", 32'(r1_rvld), 32'h0);
    chk("mf_rdata1", r1_rdata, 32'h0);
    chk("mf_mem_ena", 32'(mem_ena), 32'h0);
    chk("mf_mem_addr", 32'(mem_addr), 32'h0);
    chk("mf_mem_wdata", mem_wdata, 32'h0);
    r0_ena = 1; r0_addr = 13'h1; r0_wena = 0; r1_ena = 1; r1_addr = 13'h1; settle;
    chk("mf_tie_gnt0", 32'(r0_gnt), 32'h1);
    chk("mf_tie_gnt1", 32'(r1_gnt), 32'h0);
    tick;
    chk("mf_rvld1_late", 32'(r1_rvld), 32'h0);
    chk("mf_tie2_gnt1", 32'(r1_gnt), 32'h1);
    r0_ena = 0; r1_ena = 0;
    tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
